// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: fetch-side, decode-side and status signals of the IF/ID buffer
interface if_id_buffer_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;
  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, occupancy, stall_cycles
  );
  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_ready, id_valid, id_pc, id_instr, occupancy, stall_cycles
  );
endinterface

// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic IF/ID pipeline buffer with flush and saturating stall counter
module if_id_buffer (
  input logic clk,
  input logic reset,
  if_id_buffer_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
  state_e state_q, state_d;
  logic [63:0] head_q, head_d, tail_q, tail_d, in_entry;
  logic [15:0] stall_q, stall_d;
  logic push, pop;
  assign in_entry = {bus.if_pc, bus.if_instr};
  assign bus.if_ready = state_q != FULL;
  assign bus.id_valid = state_q != EMPTY;
  assign bus.occupancy = state_q;
  assign {bus.id_pc, bus.id_instr} = head_q;
  assign bus.stall_cycles = stall_q;
  assign push = bus.if_valid && bus.if_ready;
  assign pop = bus.id_valid && bus.id_ready;
  assign stall_d = (bus.id_valid && !bus.id_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  // head is zeroed whenever the buffer drains so an empty buffer shows PC/instr 0
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    if (bus.flush) begin
      state_d = EMPTY;
      head_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          head_d = in_entry;
        end
        ONE: if (push && pop) head_d = in_entry;
        else if (push) begin
          tail_d = in_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
          head_d = '0;
        end
        FULL: if (pop) begin
          head_d = tail_q;
          state_d = ONE;
        end
        default: begin
          state_d = EMPTY;
          head_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: table-driven, directed and random checks of if_id_buffer against a queue model
module tb_if_id_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  if_id_buffer_if bus ();
  if_id_buffer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [63:0] mq[$];
  int m_stall = 0;

  typedef struct {
    bit r; bit f; bit v; logic [31:0] pc; bit rd;
    int e_occ; logic [31:0] e_pc; int e_st;
  } vec_t;
  vec_t tbl[28];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hBEEF, ~pc[15:0]};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    cmp("m_occupancy", 32'(bus.occupancy), 32'(mq.size()));
    cmp("m_id_valid", 32'(bus.id_valid), 32'(mq.size() != 0));
    cmp("m_if_ready", 32'(bus.if_ready), 32'(mq.size() < 2));
    cmp("m_id_pc", bus.id_pc, mq.size() != 0 ? mq[0][63:32] : 32'h0);
    cmp("m_id_instr", bus.id_instr, mq.size() != 0 ? mq[0][31:0] : 32'h0);
    cmp("m_stall", 32'(bus.stall_cycles), 32'(m_stall));
  endtask

  // one clock: drive inputs, advance the model by the rules, compare after the edge
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] pc,
                      input logic [31:0] ins, input bit rd, input bit chk);
    bit m_valid, push, pop;
    reset = r; bus.flush = f; bus.if_valid = v; bus.if_pc = pc; bus.if_instr = ins; bus.id_ready = rd;
    m_valid = mq.size() != 0;
    push = v && mq.size() < 2;
    pop = m_valid && rd;
    if (r) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (m_valid && !rd && m_stall < 65535) m_stall++;
      if (f) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({pc, ins});
      end
    end
    @(posedge clk);
    #1;
    if (chk) check_model();
  endtask

  initial begin
    reset = 1'b1; bus.flush = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_instr = 0; bus.id_ready = 0;
    //            r f v  pc      rd occ pc      st
    tbl[0]  = '{1, 0, 0, 32'h00, 0, 0, 32'h00, 0};
    tbl[1]  = '{0, 0, 1, 32'h00, 1, 1, 32'h00, 0};
    tbl[2]  = '{0, 0, 1, 32'h04, 1, 1, 32'h04, 0};
    tbl[3]  = '{0, 0, 1, 32'h08, 1, 1, 32'h08, 0};
    tbl[4]  = '{0, 0, 1, 32'h0C, 1, 1, 32'h0C, 0};
    tbl[5]  = '{0, 0, 0, 32'h00, 1, 0, 32'h00, 0};
    tbl[6]  = '{0, 0, 1, 32'h10, 0, 1, 32'h10, 0};
    tbl[7]  = '{0, 0, 1, 32'h14, 0, 2, 32'h10, 1};
    tbl[8]  = '{0, 0, 1, 32'h18, 0, 2, 32'h10, 2};
    tbl[9]  = '{0, 0, 1, 32'h18, 1, 1, 32'h14, 2};
    tbl[10] = '{0, 0, 1, 32'h18, 1, 1, 32'h18, 2};
    tbl[11] = '{0, 0, 0, 32'h00, 1, 0, 32'h00, 2};
    tbl[12] = '{0, 0, 1, 32'h20, 0, 1, 32'h20, 2};
    tbl[13] = '{0, 0, 1, 32'h24, 0, 2, 32'h20, 3};
    tbl[14] = '{0, 1, 1, 32'h28, 0, 0, 32'h00, 4};
    tbl[15] = '{0, 0, 0, 32'h00, 1, 0, 32'h00, 4};
    tbl[16] = '{0, 0, 1, 32'h30, 0, 1, 32'h30, 4};
    tbl[17] = '{0, 0, 1, 32'h34, 0, 2, 32'h30, 5};
    tbl[18] = '{1, 0, 1, 32'h38, 1, 0, 32'h00, 0};
    tbl[19] = '{0, 0, 1, 32'h40, 1, 1, 32'h40, 0};
    tbl[20] = '{0, 0, 0, 32'h00, 1, 0, 32'h00, 0};
    tbl[21] = '{0, 0, 1, 32'h44, 0, 1, 32'h44, 0};
    tbl[22] = '{0, 1, 1, 32'h48, 0, 0, 32'h00, 1};
    tbl[23] = '{0, 0, 0, 32'h00, 1, 0, 32'h00, 1};
    tbl[24] = '{0, 0, 1, 32'h4C, 1, 1, 32'h4C, 1};
    tbl[25] = '{0, 1, 1, 32'h50, 1, 0, 32'h00, 1};
    tbl[26] = '{0, 0, 1, 32'h54, 1, 1, 32'h54, 1};
    tbl[27] = '{0, 0, 0, 32'h00, 1, 0, 32'h00, 1};
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].pc, instr_of(tbl[i].pc), tbl[i].rd, 1'b1);
      cmp($sformatf("t%0d_occupancy", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
      cmp($sformatf("t%0d_id_valid", i), 32'(bus.id_valid), 32'(tbl[i].e_occ != 0));
      cmp($sformatf("t%0d_if_ready", i), 32'(bus.if_ready), 32'(tbl[i].e_occ != 2));
      cmp($sformatf("t%0d_id_pc", i), bus.id_pc, tbl[i].e_pc);
      cmp($sformatf("t%0d_id_instr", i), bus.id_instr, tbl[i].e_occ != 0 ? instr_of(tbl[i].e_pc) : 32'h0);
      cmp($sformatf("t%0d_stall", i), 32'(bus.stall_cycles), 32'(tbl[i].e_st));
    end
    // stall counter saturation, flush keeps it, reset clears it
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h60, instr_of(32'h60), 0, 1);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 0, (i % 4096) == 0);
    cmp("sat_stall", 32'(bus.stall_cycles), 32'hFFFF);
    cmp("sat_pc", bus.id_pc, 32'h60);
    step(0, 0, 0, 0, 0, 0, 1);
    cmp("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);
    step(0, 1, 0, 0, 0, 0, 1);
    cmp("sat_flush", 32'(bus.stall_cycles), 32'hFFFF);
    cmp("sat_flush_valid", 32'(bus.id_valid), 32'h0);
    step(1, 0, 0, 0, 0, 0, 1);
    cmp("sat_reset", 32'(bus.stall_cycles), 32'h0);
    // random traffic against the queue model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           pc, $urandom, $urandom_range(0, 2) != 0, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
